// File: rtl/uart_frame_packer.sv
// uart_frame_packer: wraps each input word as [SYNC, SEQ, payload LSB-first, CHK]
// and streams it into a multi-push TX FIFO at up to N bytes per cycle within its credit.
module uart_frame_packer #(
  parameter int N = 4,
  parameter int WORD_BYTES = 4,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       in_valid,
  input  logic [WORD_BYTES*8-1:0]    in_data,
  output logic                       in_ready,
  input  logic [$clog2(N+1)-1:0]     can_push,
  output logic [$clog2(N+1)-1:0]     push,
  output logic [N*8-1:0]             data_o
);
  localparam int L = WORD_BYTES + 3;
  localparam int IW = $clog2(L + 1);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            r_state;
  logic [L*8-1:0]    r_frame;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_seq;
  logic [7:0]        w_chk;
  logic [CW-1:0]     w_k;
  logic [N*8-1:0]    w_lanes;
  logic              w_done;
  int                w_rem;
  int                w_cap;
  always_comb begin
    w_chk = r_seq;
    for (int j = 0; j < WORD_BYTES; j++) w_chk = w_chk + in_data[j*8 +: 8];
    w_rem = L - int'(r_idx);
    w_cap = int'(can_push) < N ? int'(can_push) : N;
    // push is gated by arstn so a reset cycle never writes the FIFO
    w_k = (arstn && r_state == SEND) ? CW'(w_rem < w_cap ? w_rem : w_cap) : '0;
    w_done = int'(r_idx) + int'(w_k) == L;
    w_lanes = (N*8)'({{(N*8){1'b0}}, r_frame} >> {r_idx, 3'b000});
    data_o = '0;
    for (int j = 0; j < N; j++) data_o[j*8 +: 8] = j < int'(w_k) ? w_lanes[j*8 +: 8] : 8'h00;
  end
  assign push = w_k;
  assign in_ready = r_state == IDLE;
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_idx   <= '0;
      r_seq   <= 8'h00;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_frame <= {w_chk, in_data, r_seq, SYNC};
        r_idx   <= '0;
        r_state <= SEND;
      end
    end else begin
      r_idx <= r_idx + IW'(w_k);
      if (w_done) begin
        r_seq   <= r_seq + 8'd1;
        r_state <= IDLE;
      end
    end
  end
endmodule
